// File: rtl/logic_shift_unit_seq_pkg.sv
// Shared op codes, FSM state type and op-class helper for the sequential logic/shift ALU slice.
package logic_shift_unit_seq_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_NOT  = 4'd2;
  localparam logic [3:0] ALU_NEG  = 4'd3;
  localparam logic [3:0] ALU_SHR  = 4'd4;
  localparam logic [3:0] ALU_SHRA = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_ROL  = 4'd7;
  localparam logic [3:0] ALU_ROR  = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  // Ops that iterate one bit per clock; everything else commits after one edge.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op >= ALU_SHR) && (op <= ALU_ROR);
  endfunction

endpackage

// File: rtl/logic_shift_unit_seq_shift_step.sv
// Combinational one-bit shift/rotate step on the {hi,lo} working pair.
module logic_shift_unit_seq_shift_step
  import logic_shift_unit_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  always_comb begin
    hi_next = hi;
    lo_next = lo;
    unique case (op)
      ALU_SHR:  lo_next = {1'b0, lo[WIDTH-1:1]};
      ALU_SHRA: lo_next = {lo[WIDTH-1], lo[WIDTH-1:1]};
      // SHL spills the outgoing MSB into the LSB of the high word
      ALU_SHL: begin
        hi_next = {hi[WIDTH-2:0], lo[WIDTH-1]};
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
      ALU_ROL:  lo_next = {lo[WIDTH-2:0], lo[WIDTH-1]};
      ALU_ROR:  lo_next = {lo[0], lo[WIDTH-1:1]};
      default: ;
    endcase
  end

endmodule

// File: rtl/logic_shift_unit_seq.sv
// Multi-cycle ALU slice: single-edge logic ops, bit-serial shifts/rotates, start/busy/done handshake.
module logic_shift_unit_seq
  import logic_shift_unit_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] Zlow,
  output logic [WIDTH-1:0] Zhigh,
  output state_t           dbg_state
);

  state_t             state, state_next;
  logic [3:0]         op_r;
  logic [WIDTH-1:0]   y_r, hi_r, lo_r;
  logic [WIDTH-1:0]   hi_step, lo_step;
  logic [WIDTH-1:0]   res_lo, res_hi;
  logic               res_err;
  logic [SHAMT_W-1:0] cnt;

  assign dbg_state = state;

  logic_shift_unit_seq_shift_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_r),
    .hi      (hi_r),
    .lo      (lo_r),
    .hi_next (hi_step),
    .lo_next (lo_step)
  );

  always_ff @(posedge clock) begin
    if (!clear) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_EXEC;
      ST_EXEC: if (cnt == '0) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // lo_r holds the captured x for logic ops and the shifting value for shift ops.
  always_comb begin
    res_lo  = '0;
    res_hi  = '0;
    res_err = 1'b0;
    unique case (op_r)
      ALU_AND: res_lo = lo_r & y_r;
      ALU_OR:  res_lo = lo_r | y_r;
      ALU_NOT: res_lo = ~y_r;
      ALU_NEG: res_lo = ~y_r + 1'b1;
      ALU_SHR, ALU_SHRA, ALU_SHL, ALU_ROL, ALU_ROR: begin
        res_lo = lo_r;
        res_hi = hi_r;
      end
      default: res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      Zlow  <= '0;
      Zhigh <= '0;
      op_r  <= '0;
      y_r   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            op_r <= op;
            y_r  <= y;
            lo_r <= x;
            hi_r <= '0;
            cnt  <= is_shift_op(op) ? y[SHAMT_W-1:0] : '0;
            busy <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (cnt != '0) begin
            hi_r <= hi_step;
            lo_r <= lo_step;
            cnt  <= cnt - 1'b1;
          end else begin
            Zlow  <= res_lo;
            Zhigh <= res_hi;
            err   <= res_err;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_shift_unit_seq.sv
// Directed bench for logic_shift_unit_seq with a queue-based scoreboard and an independent done monitor.
module tb_logic_shift_unit_seq;
  import logic_shift_unit_seq_pkg::*;

  localparam int W     = 32;
  localparam int EXP_W = 32 + 1 + 2 * W;  // {done_cycle, err, Zhigh, Zlow}

  logic         clock = 1'b0;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op    = 4'd0;
  logic [W-1:0] x     = '0;
  logic [W-1:0] y     = '0;
  logic         busy, done, err;
  logic [W-1:0] Zlow, Zhigh;
  state_t       dbg_state;

  logic_shift_unit_seq #(.WIDTH(W)) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .op        (op),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .Zlow      (Zlow),
    .Zhigh     (Zhigh),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (err === 1'b1 && done !== 1'b1) check("err_without_done", 1, 0);
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("zlow",           Zlow,  mon_e[W-1:0]);
        check("zhigh",          Zhigh, mon_e[2*W-1:W]);
        check("err",            err,   mon_e[2*W]);
        check("done_cycle",     cyc,   mon_e[EXP_W-1:2*W+1]);
        check("busy_with_done", busy,  0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic int unsigned shift_n(input logic [3:0] o, input logic [W-1:0] v);
    return (o >= 4'd4 && o <= 4'd8) ? int'(v[4:0]) : 0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) check("idle_timeout", 0, 1);
  endtask

  task automatic push_exp(input int unsigned k, input logic [3:0] o, input logic [W-1:0] yv,
                          input logic [W-1:0] e_lo, input logic [W-1:0] e_hi, input logic e_err);
    logic [31:0] dc;
    dc = k + shift_n(o, yv) + 1;
    exp_q.push_back({dc, e_err, e_hi, e_lo});
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] xv, input logic [W-1:0] yv,
                       input logic [W-1:0] e_lo, input logic [W-1:0] e_hi, input logic e_err,
                       input bit push);
    wait_idle();
    op = o; x = xv; y = yv; start = 1'b1;
    tick();
    if (push) push_exp(cyc, o, yv, e_lo, e_hi, e_err);
    start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && t < 300) begin
      tick();
      t++;
    end
    if (t >= 300) check("drain_timeout", 0, 1);
    tick();
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] prev;
  int           t;

  initial begin
    clear = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy",  busy,  0);
    check("rst_done",  done,  0);
    check("rst_err",   err,   0);
    check("rst_zlow",  Zlow,  0);
    check("rst_zhigh", Zhigh, 0);
    check("rst_state", dbg_state, ST_IDLE);
    clear = 1'b1;
    tick();

    // single-edge logic ops
    issue(ALU_NOT, 32'h0,        32'hAAAA_AAAA, 32'h5555_5555, 32'h0, 1'b0, 1);
    issue(ALU_NEG, 32'h0,        32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
    issue(ALU_NEG, 32'h1234,     32'h0000_0000, 32'h0000_0000, 32'h0, 1'b0, 1);
    issue(ALU_OR,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 32'h0, 1'b0, 1);
    issue(ALU_AND, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 32'h0, 1'b0, 1);
    drain();

    // SHRA with result held stable until commit
    prev = 32'h0F0F_0000;
    issue(ALU_SHRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 32'h0, 1'b0, 1);
    t = 0;
    while (busy === 1'b1 && t < 50) begin
      check("zlow_hold", Zlow, prev);
      tick();
      t++;
    end
    drain();

    // left shift with spill, rotates, shift amount wrapping
    issue(ALU_SHL, 32'hFFFF_0000, 32'd8,         32'hFF00_0000, 32'h0000_00FF, 1'b0, 1);
    issue(ALU_ROL, 32'h8000_0001, 32'd1,         32'h0000_0003, 32'h0,         1'b0, 1);
    issue(ALU_ROR, 32'h0000_0001, 32'd31,        32'h0000_0002, 32'h0,         1'b0, 1);
    issue(ALU_SHR, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 32'h0,         1'b0, 1);
    issue(ALU_SHR, 32'h8000_0000, 32'd35,        32'h1000_0000, 32'h0,         1'b0, 1);
    drain();

    // start pulses and operand changes while busy are ignored
    issue(ALU_ROL, 32'h0000_0001, 32'd5, 32'h0000_0020, 32'h0, 1'b0, 1);
    repeat (2) begin
      op = ALU_AND; x = 32'hDEAD_BEEF; y = 32'h0000_0001; start = 1'b1;
      tick();
      start = 1'b0;
    end
    drain();

    // back-to-back: start held high, second op accepted in the done cycle
    wait_idle();
    op = ALU_SHL; x = 32'h0000_0001; y = 32'd3; start = 1'b1;
    tick();
    push_exp(cyc, ALU_SHL, 32'd3, 32'h0000_0008, 32'h0, 1'b0);
    op = ALU_ROR; x = 32'h0000_00F0; y = 32'd4;
    t = 0;
    while (done !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check("b2b_done_timeout", 0, 1);
    tick();
    push_exp(cyc, ALU_ROR, 32'd4, 32'h0000_000F, 32'h0, 1'b0);
    start = 1'b0;
    drain();

    // reset mid-shift: aborted, outputs zeroed, no done
    issue(ALU_SHL, 32'hFFFF_FFFF, 32'd20, 32'h0, 32'h0, 1'b0, 0);
    repeat (5) tick();
    clear = 1'b0;
    tick();
    check("abort_busy",  busy,  0);
    check("abort_done",  done,  0);
    check("abort_zlow",  Zlow,  0);
    check("abort_zhigh", Zhigh, 0);
    check("abort_state", dbg_state, ST_IDLE);
    clear = 1'b1;
    repeat (30) tick();
    check("abort_no_restart", busy, 0);

    // illegal ops: one-edge latency, err with done, zero result
    issue(ALU_SHL, 32'h0000_0003, 32'd1, 32'h0000_0006, 32'h0, 1'b0, 1);
    issue(4'hF,    32'hFFFF_FFFF, 32'd3, 32'h0,         32'h0, 1'b1, 1);
    issue(4'h9,    32'h1234_5678, 32'd7, 32'h0,         32'h0, 1'b1, 1);
    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
